// File: rtl/timer_alarm_ctrl.sv
`timescale 1ns/1ps
// timer_alarm_ctrl: countdown kitchen timer with a buzzer alarm.
//   clk_clk        single clock, rising edge
//   reset_reset_n  synchronous active-low reset
//   botones_i[3:0] active-low buttons: [0] start/pause, [1] clear,
//                  [2] minutes +, [3] seconds +
//   switch_i[3:0]  [0] step 10 instead of 1, [3] mute buzzer
//   seg5_o..seg0_o active-low 7-segment digits MM:SS.t and a blank digit
//   led_o[2:0]     {ALARM, PAUSE, RUN}
//   buzzer_o       active-high buzzer drive
module timer_alarm_ctrl #(
   parameter int unsigned CLK_HZ          = 50_000_000,
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
   parameter int unsigned ALARM_SECONDS   = 10
) (
   input  logic       clk_clk,
   input  logic       reset_reset_n,
   input  logic [3:0] botones_i,
   input  logic [3:0] switch_i,
   output logic [6:0] seg0_o,
   output logic [6:0] seg1_o,
   output logic [6:0] seg2_o,
   output logic [6:0] seg3_o,
   output logic [6:0] seg4_o,
   output logic [6:0] seg5_o,
   output logic [2:0] led_o,
   output logic       buzzer_o
);

   localparam int unsigned TICK_CYC    = CLK_HZ / 10;
   localparam int unsigned PRE_W       = $clog2(TICK_CYC + 1);
   localparam int unsigned BUZZ_CYC    = CLK_HZ / 4;
   localparam int unsigned BZ_W        = $clog2(BUZZ_CYC + 1);
   localparam int unsigned ALARM_TICKS = ALARM_SECONDS * 10;
   localparam int unsigned AT_W        = $clog2(ALARM_TICKS + 1);
   localparam int unsigned DB_W        = $clog2(DEBOUNCE_CYCLES + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSE, ST_ALARM} state_t;

   // ---------------------------------------------------------------
   // Two-flop synchronizers; smp_vld masks the reset values out of the
   // debouncers so a button held through reset is seen as held.
   logic [3:0] btn_s1, btn_s2, sw_s1, sw_s2;
   logic [1:0] smp_vld;
   logic       sw_unused;

   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         btn_s1  <= '1;
         btn_s2  <= '1;
         sw_s1   <= '0;
         sw_s2   <= '0;
         smp_vld <= '0;
      end else begin
         btn_s1  <= botones_i;
         btn_s2  <= btn_s1;
         sw_s1   <= switch_i;
         sw_s2   <= sw_s1;
         smp_vld <= {smp_vld[0], 1'b1};
      end
   end

   assign sw_unused = ^sw_s2[2:1];

   // ---------------------------------------------------------------
   // Debouncers: run length of equal samples; a level is accepted once the
   // run reaches DEBOUNCE_CYCLES. A press only counts once the button has
   // been accepted as released since reset (armed).
   logic [3:0][DB_W-1:0] run_len, run_nxt;
   logic [3:0]           last_smp, acc_lvl, armed, press;

   always_comb begin
      run_nxt = run_len;
      for (int i = 0; i < 4; i++) begin
         if (btn_s2[i] != last_smp[i])
            run_nxt[i] = DB_W'(1);
         else if (run_len[i] < DB_W'(DEBOUNCE_CYCLES))
            run_nxt[i] = run_len[i] + DB_W'(1);
      end
   end

   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         run_len  <= '0;
         last_smp <= '1;
         acc_lvl  <= '1;
         armed    <= '0;
         press    <= '0;
      end else begin
         press <= '0;
         if (smp_vld[1]) begin
            last_smp <= btn_s2;
            run_len  <= run_nxt;
            for (int i = 0; i < 4; i++) begin
               if (run_nxt[i] >= DB_W'(DEBOUNCE_CYCLES)) begin
                  if (btn_s2[i])
                     armed[i] <= 1'b1;
                  if (btn_s2[i] != acc_lvl[i]) begin
                     acc_lvl[i] <= btn_s2[i];
                     press[i]   <= ~btn_s2[i] & armed[i];
                  end
               end
            end
         end
      end
   end

   // Same-cycle press priority: clear > start/pause > minutes > seconds.
   logic do_clr, do_ss, do_min, do_sec, any_press;
   assign do_clr    = press[1];
   assign do_ss     = press[0] & ~press[1];
   assign do_min    = press[2] & ~press[1] & ~press[0];
   assign do_sec    = press[3] & ~(|press[2:0]);
   assign any_press = |press;

   // ---------------------------------------------------------------
   // BCD helpers.
   function automatic logic [7:0] bcd_add(input logic [3:0] tens, input logic [3:0] units,
                                          input int unsigned step, input int unsigned modulo);
      int unsigned v;
      v = (32'(tens) * 32'd10 + 32'(units) + step) % modulo;
      return {4'(v / 32'd10), 4'(v % 32'd10)};
   endfunction

   function automatic logic [6:0] seg_enc(input logic [3:0] d);
      case (d)
         4'd0:    return 7'h40;
         4'd1:    return 7'h79;
         4'd2:    return 7'h24;
         4'd3:    return 7'h30;
         4'd4:    return 7'h19;
         4'd5:    return 7'h12;
         4'd6:    return 7'h02;
         4'd7:    return 7'h78;
         4'd8:    return 7'h00;
         4'd9:    return 7'h10;
         default: return 7'h7F;
      endcase
   endfunction

   // ---------------------------------------------------------------
   // Control FSM and time datapath.
   state_t            state;
   logic [3:0]        min_t, min_u, sec_t, sec_u, ten;
   logic [PRE_W-1:0]  presc;
   logic [BZ_W-1:0]   buzz_cnt;
   logic [AT_W-1:0]   alarm_cnt;
   logic              buzz_ph;
   logic              tick, time_zero;
   int unsigned       inc_step;

   assign tick      = (presc == PRE_W'(TICK_CYC - 1));
   assign time_zero = ((min_t | min_u | sec_t | sec_u | ten) == 4'd0);
   assign inc_step  = sw_s2[0] ? 32'd10 : 32'd1;

   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         state     <= ST_IDLE;
         min_t     <= '0;
         min_u     <= '0;
         sec_t     <= '0;
         sec_u     <= '0;
         ten       <= '0;
         presc     <= '0;
         buzz_cnt  <= '0;
         alarm_cnt <= '0;
         buzz_ph   <= 1'b0;
      end else begin
         // Free-running timebases; cleared on entry to RUN / ALARM below.
         presc <= tick ? '0 : presc + PRE_W'(1);
         if (buzz_cnt == BZ_W'(BUZZ_CYC - 1)) begin
            buzz_cnt <= '0;
            buzz_ph  <= ~buzz_ph;
         end else begin
            buzz_cnt <= buzz_cnt + BZ_W'(1);
         end

         case (state)
            ST_IDLE, ST_PAUSE: begin
               if (do_clr) begin
                  state <= ST_IDLE;
                  {min_t, min_u, sec_t, sec_u, ten} <= '0;
               end else if (do_ss) begin
                  if (state == ST_PAUSE || !time_zero) begin
                     state <= ST_RUN;
                     presc <= '0;
                  end
               end else if (do_min) begin
                  {min_t, min_u} <= bcd_add(min_t, min_u, inc_step, 32'd100);
               end else if (do_sec) begin
                  {sec_t, sec_u} <= bcd_add(sec_t, sec_u, inc_step, 32'd60);
               end
            end
            ST_RUN: begin
               if (do_clr) begin
                  state <= ST_IDLE;
                  {min_t, min_u, sec_t, sec_u, ten} <= '0;
               end else if (do_ss) begin
                  state <= ST_PAUSE;
               end else if (time_zero) begin
                  // One cycle after the decrement that reached 00:00.0.
                  state     <= ST_ALARM;
                  presc     <= '0;
                  alarm_cnt <= '0;
                  buzz_cnt  <= '0;
                  buzz_ph   <= 1'b1;
               end else if (tick) begin
                  if (ten != 4'd0) begin
                     ten <= ten - 4'd1;
                  end else begin
                     ten <= 4'd9;
                     if (sec_u != 4'd0) begin
                        sec_u <= sec_u - 4'd1;
                     end else begin
                        sec_u <= 4'd9;
                        if (sec_t != 4'd0) begin
                           sec_t <= sec_t - 4'd1;
                        end else begin
                           sec_t <= 4'd5;
                           if (min_u != 4'd0) begin
                              min_u <= min_u - 4'd1;
                           end else begin
                              min_u <= 4'd9;
                              min_t <= min_t - 4'd1;
                           end
                        end
                     end
                  end
               end
            end
            ST_ALARM: begin
               // Time is already 00:00.0 here; any press just dismisses.
               if (any_press) begin
                  state <= ST_IDLE;
               end else if (tick) begin
                  if (alarm_cnt == AT_W'(ALARM_TICKS - 1))
                     state <= ST_IDLE;
                  else
                     alarm_cnt <= alarm_cnt + AT_W'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------
   // Registered outputs.
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         seg5_o   <= 7'h40;
         seg4_o   <= 7'h40;
         seg3_o   <= 7'h40;
         seg2_o   <= 7'h40;
         seg1_o   <= 7'h40;
         seg0_o   <= 7'h7F;
         led_o    <= 3'b000;
         buzzer_o <= 1'b0;
      end else begin
         seg5_o   <= seg_enc(min_t);
         seg4_o   <= seg_enc(min_u);
         seg3_o   <= seg_enc(sec_t);
         seg2_o   <= seg_enc(sec_u);
         seg1_o   <= seg_enc(ten);
         seg0_o   <= 7'h7F;
         led_o    <= {state == ST_ALARM, state == ST_PAUSE, state == ST_RUN};
         buzzer_o <= (state == ST_ALARM) && buzz_ph && !sw_s2[3];
      end
   end

endmodule
